// File: rtl/xgmii_pkg.sv
// Shared definitions for the XGMII frame generator.
//   - XGMII control characters and whole-word constants
//   - CRC-32 constants (reflected IEEE 802.3)
//   - frame generator FSM state type
//   - frame length clamp helper
package xgmii_pkg;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERR   = 8'hFE;

  // Start character in lane 0, six preamble bytes, SFD in lane 7.
  localparam logic [63:0] PREAMBLE_WORD = 64'hD5555555555555FB;
  localparam logic [7:0]  PREAMBLE_CTRL = 8'h01;
  localparam logic [63:0] IDLE_WORD     = {8{XGMII_IDLE}};
  localparam logic [7:0]  IDLE_CTRL     = 8'hFF;

  localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  // Register value after running data+FCS through the reflected CRC;
  // its bit-reversed form is the familiar C704DD7B.
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_DATA,
    ST_TERM,
    ST_IFG
  } fsm_state_t;

  function automatic logic [10:0] clamp_len(input logic [10:0] len,
                                            input logic [10:0] lo,
                                            input logic [10:0] hi);
    if (len < lo) return lo;
    if (len > hi) return hi;
    return len;
  endfunction

endpackage

// File: rtl/crc32_d64.sv
// CRC-32 (IEEE 802.3, reflected) over up to 8 bytes per clock.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   data               : byte lanes, lane0 = [7:0] is processed first
//   nbytes             : number of valid lanes starting at lane 0 (0..8)
//   init               : load the CRC register with FFFFFFFF
//   en                 : fold the valid lanes into the CRC register
//   crc                : registered CRC state (not inverted)
//   crc_next           : CRC state including the current lanes
module crc32_d64
  import xgmii_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [63:0] data,
  input  logic [3:0]  nbytes,
  input  logic        init,
  input  logic        en,
  output logic [31:0] crc,
  output logic [31:0] crc_next
);

  logic [31:0] c;

  always_comb begin
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < nbytes) begin
        c = c ^ {24'h0, data[8*i +: 8]};
        for (int b = 0; b < 8; b++) begin
          c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
      end
    end
    crc_next = c;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  crc <= CRC32_INIT;
    else if (init)   crc <= CRC32_INIT;
    else if (en)     crc <= crc_next;
  end

endmodule

// File: rtl/xgmii_frame_gen.sv
// XGMII 10GbE frame generator: preamble/SFD, programmable header,
// sequence-numbered payload, FCS, terminate and inter-frame gap.
//   sys_clk, sys_rst_n : XGMII clock, async active-low reset
//   start              : pulse, starts a burst when idle
//   stop               : level, ends the burst after the current frame
//   frame_len          : bytes excl. FCS (clamped), sampled at start
//   frame_count        : frames per burst, 0 = continuous
//   dst_mac, src_mac, ethertype : header fields, sampled at start
//   xgmii_txd/txc      : 64-bit XGMII data/control, lane0 = [7:0]
//   busy               : burst in progress
//   frames_sent        : frames completed since reset (wraps)
//
// state   | meaning
// IDLE    | idle words, waiting for start
// SOF     | preamble/SFD word
// DATA    | header, payload and FCS words except the last
// TERM    | word holding the FD character
// IFG     | IFG_WORDS idle words, then next frame or IDLE
module xgmii_frame_gen
  import xgmii_pkg::*;
#(
  parameter int IFG_WORDS = 2,
  parameter int MIN_LEN   = 60,
  parameter int MAX_LEN   = 1514
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [10:0] frame_len,
  input  logic [15:0] frame_count,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] ethertype,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  output logic        busy,
  output logic [31:0] frames_sent
);

  localparam int IFGW = (IFG_WORDS > 1) ? $clog2(IFG_WORDS) : 1;
  localparam logic [IFGW-1:0] IFG_LOAD = IFGW'(IFG_WORDS - 1);
  localparam logic [10:0] LEN_MIN = 11'(MIN_LEN);
  localparam logic [10:0] LEN_MAX = 11'(MAX_LEN);

  fsm_state_t state_q, state_d;

  logic [10:0]     len_q;
  logic [15:0]     count_q;
  logic [47:0]     dst_q, src_q;
  logic [15:0]     type_q;
  logic [31:0]     seq_q;
  logic            stop_seen;
  logic [11:0]     base_q;     // byte index of lane 0 in the current word
  logic [7:0]      wcnt_q;     // DATA words left after this one
  logic [IFGW-1:0] ifg_q;

  logic            frame_done, last_of_burst;
  logic [11:0]     nwords, len_ext, data_rem;
  logic            has_data;
  logic [11:0]     lane_idx [8];
  logic [1:0]      fcs_sel  [8];
  logic [63:0]     crc_data;
  logic [3:0]      crc_nbytes;
  logic            crc_en, crc_init;
  logic [31:0]     crc_q, crc_next, fcs;

  assign len_ext       = {1'b0, len_q};
  assign nwords        = (len_ext + 12'd12) >> 3;
  assign last_of_burst = (count_q != 16'd0) && ((seq_q + 32'd1) == {16'd0, count_q});
  assign busy          = (state_q != ST_IDLE);

  function automatic logic [7:0] frame_byte(input logic [11:0] idx);
    case (idx)
      12'd0:   return dst_q[47:40];
      12'd1:   return dst_q[39:32];
      12'd2:   return dst_q[31:24];
      12'd3:   return dst_q[23:16];
      12'd4:   return dst_q[15:8];
      12'd5:   return dst_q[7:0];
      12'd6:   return src_q[47:40];
      12'd7:   return src_q[39:32];
      12'd8:   return src_q[31:24];
      12'd9:   return src_q[23:16];
      12'd10:  return src_q[15:8];
      12'd11:  return src_q[7:0];
      12'd12:  return type_q[15:8];
      12'd13:  return type_q[7:0];
      12'd14:  return seq_q[31:24];
      12'd15:  return seq_q[23:16];
      12'd16:  return seq_q[15:8];
      12'd17:  return seq_q[7:0];
      default: return idx[7:0] - 8'd14;
    endcase
  endfunction

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_SOF;
      ST_SOF:  state_d = ST_DATA;
      ST_DATA: if (wcnt_q == 8'd0) state_d = ST_TERM;
      ST_TERM: state_d = ST_IFG;
      ST_IFG: begin
        if (ifg_q == '0) begin
          frame_done = 1'b1;
          // stop is looked at in this cycle too, so a late stop still ends the burst
          state_d = (last_of_burst || stop_seen || stop) ? ST_IDLE : ST_SOF;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      len_q       <= '0;
      count_q     <= '0;
      dst_q       <= '0;
      src_q       <= '0;
      type_q      <= '0;
      seq_q       <= '0;
      stop_seen   <= 1'b0;
      base_q      <= '0;
      wcnt_q      <= '0;
      ifg_q       <= '0;
      frames_sent <= '0;
    end else begin
      if (state_q != ST_IDLE && stop) stop_seen <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_q     <= clamp_len(frame_len, LEN_MIN, LEN_MAX);
            count_q   <= frame_count;
            dst_q     <= dst_mac;
            src_q     <= src_mac;
            type_q    <= ethertype;
            seq_q     <= '0;
            stop_seen <= stop;
          end
        end
        ST_SOF: begin
          base_q <= '0;
          wcnt_q <= 8'(nwords - 12'd2);
        end
        ST_DATA: begin
          base_q <= base_q + 12'd8;
          if (wcnt_q != 8'd0) wcnt_q <= wcnt_q - 8'd1;
        end
        ST_TERM: begin
          base_q <= base_q + 12'd8;
          ifg_q  <= IFG_LOAD;
        end
        ST_IFG: begin
          if (ifg_q != '0) begin
            ifg_q <= ifg_q - 1'b1;
          end else begin
            seq_q       <= seq_q + 32'd1;
            frames_sent <= frames_sent + 32'd1;
            stop_seen   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Lane byte indices and the data-only view of the current word for the CRC.
  always_comb begin
    has_data   = len_ext > base_q;
    data_rem   = len_ext - base_q;
    crc_nbytes = 4'd0;
    if (has_data) crc_nbytes = (data_rem >= 12'd8) ? 4'd8 : data_rem[3:0];
    crc_en   = has_data && (state_q == ST_DATA || state_q == ST_TERM);
    crc_init = (state_q == ST_SOF);
    crc_data = '0;
    for (int i = 0; i < 8; i++) begin
      lane_idx[i] = base_q + 12'(i);
      fcs_sel[i]  = lane_idx[i][1:0] - len_q[1:0];
      crc_data[8*i +: 8] = frame_byte(lane_idx[i]);
    end
  end

  crc32_d64 u_crc (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .data      (crc_data),
    .nbytes    (crc_nbytes),
    .init      (crc_init),
    .en        (crc_en),
    .crc       (crc_q),
    .crc_next  (crc_next)
  );

  // When the payload ends inside this word the FCS has to include the
  // word's own data bytes, so it comes from the combinational update.
  assign fcs = has_data ? ~crc_next : ~crc_q;

  always_comb begin
    xgmii_txd = IDLE_WORD;
    xgmii_txc = IDLE_CTRL;
    case (state_q)
      ST_IDLE, ST_IFG: ;
      ST_SOF: begin
        xgmii_txd = PREAMBLE_WORD;
        xgmii_txc = PREAMBLE_CTRL;
      end
      ST_DATA, ST_TERM: begin
        for (int i = 0; i < 8; i++) begin
          if (lane_idx[i] < len_ext) begin
            xgmii_txd[8*i +: 8] = crc_data[8*i +: 8];
            xgmii_txc[i]        = 1'b0;
          end else if (lane_idx[i] < len_ext + 12'd4) begin
            xgmii_txd[8*i +: 8] = fcs[{fcs_sel[i], 3'b000} +: 8];
            xgmii_txc[i]        = 1'b0;
          end else if (lane_idx[i] == len_ext + 12'd4) begin
            xgmii_txd[8*i +: 8] = XGMII_TERM;
          end
        end
      end
      default: xgmii_txd = {8{XGMII_ERR}};
    endcase
  end

endmodule

// File: tb/tb_xgmii_frame_gen.sv
module tb_xgmii_frame_gen;

  localparam int IFG_WORDS = 2;
  localparam logic [63:0] SOF_W  = 64'hD5555555555555FB;
  localparam logic [63:0] IDLE_W = 64'h0707070707070707;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [10:0] frame_len = '0;
  logic [15:0] frame_count = '0;
  logic [47:0] dst_mac = '0;
  logic [47:0] src_mac = '0;
  logic [15:0] ethertype = '0;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic        busy;
  logic [31:0] frames_sent;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [31:0] fs_exp = 0;

  logic [63:0] exp_d[$];
  logic [7:0]  exp_c[$];
  logic [63:0] obs_d[$];
  logic [7:0]  obs_c[$];
  int          obs_term_idx;
  logic [7:0]  obs_term_c;
  logic [31:0] obs_residue;
  int          sof_cyc;

  xgmii_frame_gen #(.IFG_WORDS(IFG_WORDS), .MIN_LEN(60), .MAX_LEN(1514)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .start       (start),
    .stop        (stop),
    .frame_len   (frame_len),
    .frame_count (frame_count),
    .dst_mac     (dst_mac),
    .src_mac     (src_mac),
    .ethertype   (ethertype),
    .xgmii_txd   (xgmii_txd),
    .xgmii_txc   (xgmii_txc),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  always #3 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    repeat (8) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic int clamp(input int l);
    if (l < 60) return 60;
    if (l > 1514) return 1514;
    return l;
  endfunction

  // Reference frame: byte stream from the header/payload rules, FCS appended,
  // then FD and idle padding, packed into words, then the IFG words.
  task automatic build_frame(input int L, input logic [31:0] seq);
    logic [7:0]  s[$];
    logic        k[$];
    logic [47:0] t48;
    logic [15:0] t16;
    logic [31:0] t32;
    logic [31:0] crc;
    logic [63:0] w;
    logic [7:0]  c;
    for (int i = 0; i < L; i++) begin
      if (i < 6)       begin t48 = dst_mac >> (8 * (5 - i));   s.push_back(t48[7:0]); end
      else if (i < 12) begin t48 = src_mac >> (8 * (11 - i));  s.push_back(t48[7:0]); end
      else if (i < 14) begin t16 = ethertype >> (8 * (13 - i)); s.push_back(t16[7:0]); end
      else if (i < 18) begin t32 = seq >> (8 * (17 - i));      s.push_back(t32[7:0]); end
      else s.push_back(8'((i - 14) % 256));
    end
    crc = 32'hFFFFFFFF;
    foreach (s[i]) crc = crc_byte(crc, s[i]);
    crc = ~crc;
    for (int i = 0; i < 4; i++) begin t32 = crc >> (8 * i); s.push_back(t32[7:0]); end
    foreach (s[i]) k.push_back(1'b0);
    s.push_back(8'hFD); k.push_back(1'b1);
    while (s.size() % 8 != 0) begin s.push_back(8'h07); k.push_back(1'b1); end
    exp_d.delete(); exp_c.delete();
    exp_d.push_back(SOF_W); exp_c.push_back(8'h01);
    for (int wi = 0; wi < s.size() / 8; wi++) begin
      for (int l = 0; l < 8; l++) begin
        w[8*l +: 8] = s[8*wi + l];
        c[l]        = k[8*wi + l];
      end
      exp_d.push_back(w); exp_c.push_back(c);
    end
    repeat (IFG_WORDS) begin exp_d.push_back(IDLE_W); exp_c.push_back(8'hFF); end
  endtask

  task automatic pulse_start();
    @(posedge sys_clk); #1 start = 1'b1;
    @(posedge sys_clk); #1 start = 1'b0;
  endtask

  // Waits for a SOF word, then checks every word through the IFG.
  // At word stop_at, raises stop and pulses start (which must be ignored).
  task automatic check_frame(input int L, input logic [31:0] seq, input int stop_at, input string tag);
    bit          found;
    bit          in_frame;
    logic [31:0] r;
    build_frame(clamp(L), seq);
    obs_d.delete(); obs_c.delete();
    found = 0;
    for (int t = 0; t < 64 && !found; t++) begin
      @(negedge sys_clk);
      if (xgmii_txc === 8'h01 && xgmii_txd === SOF_W) found = 1;
    end
    n_cmp++;
    if (!found || busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s sof: found=%0d busy=%b, required found=1 busy=1", tag, found, busy);
      if (!found) return;
    end
    sof_cyc = cyc;
    obs_term_idx = -1;
    obs_term_c = 8'h00;
    r = 32'hFFFFFFFF;
    in_frame = 1;
    for (int w = 1; w < exp_d.size(); w++) begin
      @(negedge sys_clk);
      if (w == stop_at) begin stop = 1'b1; start = 1'b1; end
      else if (w == stop_at + 1) start = 1'b0;
      obs_d.push_back(xgmii_txd); obs_c.push_back(xgmii_txc);
      n_cmp++;
      if (xgmii_txd !== exp_d[w] || xgmii_txc !== exp_c[w] || busy !== 1'b1) begin
        n_err++;
        $display("FAIL %s word %0d: txd=%h txc=%h busy=%b, required txd=%h txc=%h busy=1",
                 tag, w, xgmii_txd, xgmii_txc, busy, exp_d[w], exp_c[w]);
      end
      for (int l = 0; l < 8; l++) begin
        if (in_frame) begin
          if (xgmii_txc[l] === 1'b0) r = crc_byte(r, xgmii_txd[8*l +: 8]);
          else begin in_frame = 0; obs_term_idx = w; obs_term_c = xgmii_txc; end
        end
      end
    end
    obs_residue = r;
  endtask

  task automatic check_idle_after(input string tag);
    @(negedge sys_clk);
    n_cmp++;
    if (busy !== 1'b0 || frames_sent !== fs_exp || xgmii_txd !== IDLE_W || xgmii_txc !== 8'hFF) begin
      n_err++;
      $display("FAIL %s idle: busy=%b frames_sent=%0d txd=%h txc=%h, required busy=0 frames_sent=%0d idle word",
               tag, busy, frames_sent, xgmii_txd, xgmii_txc, fs_exp);
    end
  endtask

  task automatic check_no_sof(input string tag, input int cycles);
    bit seen = 0;
    for (int t = 0; t < cycles; t++) begin
      @(negedge sys_clk);
      if (xgmii_txc !== 8'hFF || busy !== 1'b0) seen = 1;
    end
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("FAIL %s stays idle: activity seen=1, required 0", tag);
    end
  endtask

  task automatic test_reset();
    #2 sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    n_cmp++;
    if (xgmii_txd !== IDLE_W || xgmii_txc !== 8'hFF || busy !== 1'b0 || frames_sent !== 32'd0) begin
      n_err++;
      $display("FAIL reset: txd=%h txc=%h busy=%b frames_sent=%0d, required idle word txc=ff busy=0 frames_sent=0",
               xgmii_txd, xgmii_txc, busy, frames_sent);
    end
    sys_rst_n = 1'b1;
    fs_exp = 0;
    check_idle_after("post_reset");
  endtask

  task automatic test_single();
    dst_mac = 48'hFFFFFFFFFFFF; src_mac = 48'h001122334455; ethertype = 16'h0800;
    frame_len = 11'd60; frame_count = 16'd1;
    pulse_start();
    check_frame(60, 0, -1, "single");
    fs_exp++;
    n_cmp++;
    if (obs_d.size() < 9 || obs_d[0] !== 64'h1100FFFFFFFFFFFF || obs_d[1] !== 64'h0000000855443322 ||
        obs_d[8] !== 64'h07070707070707FD || obs_c[8] !== 8'hFF) begin
      n_err++;
      $display("FAIL single fixed words: w1=%h w2=%h w9=%h c9=%h, required 1100ffffffffffff 0000000855443322 07070707070707fd ff",
               obs_d.size() > 0 ? obs_d[0] : 64'h0, obs_d.size() > 1 ? obs_d[1] : 64'h0,
               obs_d.size() > 8 ? obs_d[8] : 64'h0, obs_c.size() > 8 ? obs_c[8] : 8'h0);
    end
    check_idle_after("single");
  endtask

  task automatic test_lengths();
    int lens[3] = '{61, 20, 2000};
    int term_w[3] = '{9, 9, 190};
    logic [7:0] term_c[3] = '{8'hFE, 8'hFF, 8'hC0};
    frame_count = 16'd1;
    for (int i = 0; i < 3; i++) begin
      dst_mac = {16'($urandom), 32'($urandom)}; src_mac = {16'($urandom), 32'($urandom)};
      ethertype = 16'($urandom);
      frame_len = 11'(lens[i]);
      pulse_start();
      check_frame(lens[i], 0, -1, "length");
      fs_exp++;
      n_cmp++;
      if (obs_term_idx != term_w[i] || obs_term_c !== term_c[i] || obs_residue !== 32'hDEBB20E3) begin
        n_err++;
        $display("FAIL length %0d term: word=%0d txc=%h residue=%h, required word=%0d txc=%h residue=debb20e3",
                 lens[i], obs_term_idx, obs_term_c, obs_residue, term_w[i], term_c[i]);
      end
      check_idle_after("length");
    end
  endtask

  task automatic test_random();
    int L;
    frame_count = 16'd1;
    for (int i = 0; i < 4; i++) begin
      dst_mac = {16'($urandom), 32'($urandom)}; src_mac = {16'($urandom), 32'($urandom)};
      ethertype = 16'($urandom);
      L = int'($urandom_range(40, 1600));
      frame_len = 11'(L);
      pulse_start();
      check_frame(L, 0, -1, "random");
      fs_exp++;
      check_idle_after("random");
    end
  endtask

  task automatic test_back_to_back();
    int prev;
    dst_mac = {16'($urandom), 32'($urandom)}; src_mac = {16'($urandom), 32'($urandom)};
    ethertype = 16'($urandom);
    frame_len = 11'd64; frame_count = 16'd3;
    pulse_start();
    prev = 0;
    for (int f = 0; f < 3; f++) begin
      check_frame(64, 32'(f), -1, "burst");
      if (f > 0) begin
        n_cmp++;
        if (sof_cyc - prev != 12) begin
          n_err++;
          $display("FAIL burst spacing %0d: %0d cycles, required 12", f, sof_cyc - prev);
        end
      end
      prev = sof_cyc;
    end
    fs_exp += 3;
    check_idle_after("burst");
  endtask

  task automatic test_stop();
    int L;
    L = int'($urandom_range(60, 200));
    dst_mac = {16'($urandom), 32'($urandom)}; src_mac = {16'($urandom), 32'($urandom)};
    ethertype = 16'($urandom);
    frame_len = 11'(L); frame_count = 16'd0;
    pulse_start();
    for (int f = 0; f < 5; f++) check_frame(L, 32'(f), (f == 4) ? 3 : -1, "stop");
    stop = 1'b0;
    fs_exp += 5;
    check_idle_after("stop");
    check_no_sof("stop", 20);
  endtask

  task automatic test_start_stop_same();
    frame_len = 11'd80; frame_count = 16'd0;
    @(posedge sys_clk); #1 start = 1'b1; stop = 1'b1;
    @(posedge sys_clk); #1 start = 1'b0; stop = 1'b0;
    check_frame(80, 0, -1, "start_stop");
    fs_exp++;
    check_idle_after("start_stop");
    check_no_sof("start_stop", 20);
  endtask

  task automatic test_reset_mid();
    frame_len = 11'd100; frame_count = 16'd0;
    pulse_start();
    repeat (5) @(negedge sys_clk);
    #1 sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (xgmii_txd !== IDLE_W || xgmii_txc !== 8'hFF || busy !== 1'b0 || frames_sent !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid: txd=%h txc=%h busy=%b frames_sent=%0d, required idle word txc=ff busy=0 frames_sent=0",
               xgmii_txd, xgmii_txc, busy, frames_sent);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    fs_exp = 0;
    dst_mac = {16'($urandom), 32'($urandom)};
    frame_len = 11'd60; frame_count = 16'd1;
    pulse_start();
    check_frame(60, 0, -1, "after_reset");
    fs_exp++;
    check_idle_after("after_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_lengths();
    test_random();
    test_back_to_back();
    test_stop();
    test_start_stop_same();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
